l2_mem_responder: RTL and testbench

- Memory-side responder (slave end) of the L2 memory interface: accepts requests from the L2 arbiter's address queue, consumes write-data beats, and returns read data tagged with the request id.
- Backed by an internal single-port word RAM with 1-cycle read latency.
- Serves as a simulation/FPGA memory target and as the reference responder for arbiter verification.
- Processes requests strictly in order, one at a time.

---
 rtl/l2_mem_responder_if.sv | 37 +++
 rtl/l2_mem_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_l2_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_mem_responder_if.sv
// L2 memory interface bundle between the arbiter (master) and
// the memory-side responder (slave).
interface l2_mem_responder_if #(
    parameter int ID_W = 4
);
    logic            request_valid;
    logic            request_pop;
    logic [29:0]     addr;
    logic            rnw;
    logic            is_amo;
    logic [4:0]      amo_type_or_burst_size;
    logic [ID_W-1:0] id;
    logic            abort_request;
    logic [31:0]     wr_data;
    logic [3:0]      wr_data_be;
    logic            wr_data_valid;
    logic            wr_data_read;
    logic [31:0]     rd_data;
    logic [ID_W-1:0] rd_id;
    logic            rd_data_valid;

    modport master (
        output request_valid, addr, rnw, is_amo,
        output amo_type_or_burst_size, id, abort_request,
        output wr_data, wr_data_be, wr_data_valid,
        input  request_pop, wr_data_read,
        input  rd_data, rd_id, rd_data_valid
    );

    modport slave (
        input  request_valid, addr, rnw, is_amo,
        input  amo_type_or_burst_size, id, abort_request,
        input  wr_data, wr_data_be, wr_data_valid,
        output request_pop, wr_data_read,
        output rd_data, rd_id, rd_data_valid
    );
endinterface

// File: rtl/l2_mem_responder.sv
// In-order L2 memory responder over a 1-cycle-latency word RAM.
// Define L2_RESP_AMO_EN to enable the read-modify-write AMO path.
module l2_mem_responder #(
    parameter int MEM_ADDR_W     = 12,
    parameter int ID_W           = 4,
    parameter int SC_ABORT_CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    l2_mem_responder_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_SC_CHECK, S_AMO_RD, S_AMO_WR
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_mem [2**MEM_ADDR_W];
    logic [MEM_ADDR_W-1:0]     r_addr;
    logic [4:0]                r_mask;
    logic [4:0]                r_beat;
    logic [ID_W-1:0]           r_id;
    logic [31:0]               r_rd_data;
    logic [ID_W-1:0]           r_rd_id;
    logic                      r_rd_valid;
    logic [SC_ABORT_CNT_W-1:0] r_sc_cnt;

    logic                  w_pop;
    logic                  w_wr_read;
    logic                  w_we;
    logic [31:0]           w_wdata;
    logic [3:0]            w_be;
    logic                  w_rd_issue;
    logic                  w_beat_inc;
    logic                  w_consume;
    logic                  w_abort_pend;
    logic                  w_sat;
    logic                  w_last;
    logic                  w_is_lr;
    logic                  w_is_sc;
    logic [MEM_ADDR_W-1:0] w_mask;
    logic [MEM_ADDR_W-1:0] w_off;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic                  w_unused_addr;

`ifdef L2_RESP_AMO_EN
    logic [4:0] r_fn;

    function automatic logic [31:0] amo_op(
        input logic [4:0]  fn,
        input logic [31:0] a,
        input logic [31:0] b
    );
        case (fn)
            5'b00000: amo_op = a + b;
            5'b00100: amo_op = a ^ b;
            5'b01100: amo_op = a & b;
            5'b01000: amo_op = a | b;
            5'b10000: amo_op = ($signed(a) < $signed(b)) ? a : b;
            5'b10100: amo_op = ($signed(a) > $signed(b)) ? a : b;
            5'b11000: amo_op = (a < b) ? a : b;
            5'b11100: amo_op = (a > b) ? a : b;
            default:  amo_op = b;
        endcase
    endfunction
`endif

    assign w_unused_addr = ^bus.addr[29:MEM_ADDR_W];

    assign w_is_lr = bus.is_amo && (bus.amo_type_or_burst_size == 5'b00010);
    assign w_is_sc = bus.is_amo && (bus.amo_type_or_burst_size == 5'b00011);

    // Beat k wraps inside the aligned block of the burst length.
    assign w_mask = MEM_ADDR_W'(r_mask);
    assign w_off  = r_addr + MEM_ADDR_W'(r_beat);
    assign w_idx  = (r_addr & ~w_mask) | (w_off & w_mask);
    assign w_last = (r_beat == r_mask);

    assign w_abort_pend = (r_sc_cnt != '0) || bus.abort_request;
    assign w_sat = bus.abort_request && !w_consume && (&r_sc_cnt);

    assign bus.request_pop   = rst && w_pop;
    assign bus.wr_data_read  = rst && w_wr_read;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_id         = r_rd_id;
    assign bus.rd_data_valid = r_rd_valid;

    // Next-state and handshake decode for the request sequencer.
    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_wr_read  = 1'b0;
        w_we       = 1'b0;
        w_wdata    = bus.wr_data;
        w_be       = bus.wr_data_be;
        w_rd_issue = 1'b0;
        w_beat_inc = 1'b0;
        w_consume  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.request_valid) begin
                    w_pop = 1'b1;
                    if (bus.rnw || w_is_lr) begin
                        w_next = S_READ;
                    end else if (w_is_sc) begin
                        w_next = S_SC_CHECK;
`ifdef L2_RESP_AMO_EN
                    end else if (bus.is_amo) begin
                        w_next = S_AMO_RD;
`endif
                    end else begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_READ: begin
                w_rd_issue = 1'b1;
                w_beat_inc = 1'b1;
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_WRITE: begin
                if (bus.wr_data_valid) begin
                    w_wr_read  = 1'b1;
                    w_we       = 1'b1;
                    w_beat_inc = 1'b1;
                    if (w_last) begin
                        w_next = S_IDLE;
                    end
                end
            end
            S_SC_CHECK: begin
                if (w_abort_pend) begin
                    w_consume = 1'b1;
                    w_next    = S_IDLE;
                end else if (bus.wr_data_valid) begin
                    w_wr_read = 1'b1;
                    w_we      = 1'b1;
                    w_next    = S_IDLE;
                end
            end
`ifdef L2_RESP_AMO_EN
            S_AMO_RD: begin
                w_rd_issue = 1'b1;
                w_next     = S_AMO_WR;
            end
            S_AMO_WR: begin
                if (bus.wr_data_valid) begin
                    w_wr_read = 1'b1;
                    w_we      = 1'b1;
                    w_wdata   = amo_op(r_fn, r_rd_data, bus.wr_data);
                    w_be      = 4'hF;
                    w_next    = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Latch the popped request and advance the beat counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr <= '0;
            r_mask <= '0;
            r_beat <= '0;
            r_id   <= '0;
`ifdef L2_RESP_AMO_EN
            r_fn   <= '0;
`endif
        end else if (w_pop) begin
            r_addr <= bus.addr[MEM_ADDR_W-1:0];
            r_mask <= bus.is_amo ? 5'd0 : bus.amo_type_or_burst_size;
            r_beat <= '0;
            r_id   <= bus.id;
`ifdef L2_RESP_AMO_EN
            r_fn   <= bus.amo_type_or_burst_size;
`endif
        end else if (w_beat_inc) begin
            r_beat <= r_beat + 5'd1;
        end
    end

    // Byte-enabled RAM write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (rst && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Registered RAM read; the output register is the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data  <= '0;
            r_rd_id    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_data <= r_mem[w_idx];
                r_rd_id   <= r_id;
            end
        end
    end

    // Pending SC aborts; arrival and consumption together cancel out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sc_cnt <= '0;
        end else if (bus.abort_request && !w_consume && !w_sat) begin
            r_sc_cnt <= r_sc_cnt + 1'b1;
        end else if (!bus.abort_request && w_consume) begin
            r_sc_cnt <= r_sc_cnt - 1'b1;
        end
    end

    a_sc_cnt_no_sat: assert property (
        @(posedge clk) disable iff (!rst) !w_sat
    );
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed self-checking bench for l2_mem_responder.
// AMO vectors follow the L2_RESP_AMO_EN build setting.
module tb_l2_mem_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l2_mem_responder_if #(.ID_W(4)) bus ();

    l2_mem_responder #(
        .MEM_ADDR_W(12),
        .ID_W(4),
        .SC_ABORT_CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] wd [32];
    logic [31:0] ew [32];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [29:0] a, input logic rn,
                       input logic amo, input logic [4:0] f,
                       input logic [3:0] i);
        @(posedge clk); #1;
        bus.request_valid          = 1'b1;
        bus.addr                   = a;
        bus.rnw                    = rn;
        bus.is_amo                 = amo;
        bus.amo_type_or_burst_size = f;
        bus.id                     = i;
        @(negedge clk);
        check("pop", bus.request_pop, 1);
        @(posedge clk); #1;
        bus.request_valid = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic rn,
                      input logic amo, input logic [4:0] f,
                      input int n, input logic [3:0] i);
        req(a, rn, amo, f, i);
        @(negedge clk);
        check("rd_valid_early", bus.rd_data_valid, 0);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("rd_valid", bus.rd_data_valid, 1);
            check("rd_data", bus.rd_data, ew[k]);
            check("rd_id", 32'(bus.rd_id), 32'(i));
        end
        @(negedge clk);
        check("rd_valid_tail", bus.rd_data_valid, 0);
    endtask

    task automatic wr(input logic [29:0] a, input logic amo,
                      input logic [4:0] f, input int n,
                      input logic [3:0] be, input logic [3:0] i);
        req(a, 1'b0, amo, f, i);
        for (int k = 0; k < n; k++) begin
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = wd[k];
            bus.wr_data_be    = be;
            @(negedge clk);
            check("wr_read", bus.wr_data_read, 1);
            check("wr_no_rd", bus.rd_data_valid, 0);
            @(posedge clk); #1;
        end
        bus.wr_data_valid = 1'b0;
    endtask

    task automatic sc(input logic [29:0] a, input logic ab,
                      input logic dv, input logic [3:0] i);
        req(a, 1'b0, 1'b1, 5'b00011, i);
        bus.abort_request = ab;
        bus.wr_data_valid = dv;
        bus.wr_data       = 32'hDEAD0000;
        bus.wr_data_be    = 4'hF;
        @(negedge clk);
        check("sc_abort_no_wr", bus.wr_data_read, 0);
        @(posedge clk); #1;
        bus.abort_request = 1'b0;
        bus.wr_data_valid = 1'b0;
    endtask

    task automatic amo(input logic [29:0] a, input logic [4:0] fn,
                       input logic [31:0] d, input logic [31:0] old,
                       input logic [3:0] i);
        req(a, 1'b0, 1'b1, fn, i);
        bus.wr_data_valid = 1'b1;
        bus.wr_data       = d;
        bus.wr_data_be    = 4'h0;
        @(negedge clk);
        check("amo_rd_wait", bus.wr_data_read, 0);
        check("amo_rd_novalid", bus.rd_data_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("amo_valid", bus.rd_data_valid, 1);
        check("amo_old", bus.rd_data, old);
        check("amo_id", 32'(bus.rd_id), 32'(i));
        check("amo_wr_read", bus.wr_data_read, 1);
        @(posedge clk); #1;
        bus.wr_data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst                        = 1'b0;
        bus.request_valid          = 1'b1;
        bus.addr                   = '0;
        bus.rnw                    = 1'b0;
        bus.is_amo                 = 1'b0;
        bus.amo_type_or_burst_size = '0;
        bus.id                     = '0;
        bus.abort_request          = 1'b0;
        bus.wr_data                = '0;
        bus.wr_data_be             = '0;
        bus.wr_data_valid          = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_pop", bus.request_pop, 0);
            check("rst_wr_read", bus.wr_data_read, 0);
            check("rst_rd_valid", bus.rd_data_valid, 0);
        end
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_id", 32'(bus.rd_id), 0);
        @(posedge clk); #1;
        rst               = 1'b1;
        bus.request_valid = 1'b0;
        bus.wr_data_valid = 1'b0;

        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wr(30'h40, 1'b0, 5'd3, 4, 4'hF, 4'd3);
        ew[0] = 32'hA0; ew[1] = 32'hA1; ew[2] = 32'hA2; ew[3] = 32'hA3;
        rd(30'h40, 1'b1, 1'b0, 5'd3, 4, 4'd5);

        ew[0] = 32'hA2; ew[1] = 32'hA3; ew[2] = 32'hA0; ew[3] = 32'hA1;
        rd(30'h42, 1'b1, 1'b0, 5'd3, 4, 4'd9);

        wd[0] = 32'hCAFE0001;
        wr(30'h2000_0100, 1'b0, 5'd0, 1, 4'hF, 4'd1);
        ew[0] = 32'hCAFE0001;
        rd(30'h0000_0100, 1'b1, 1'b0, 5'd0, 1, 4'd2);

        wd[0] = 32'h11223344;
        wr(30'h80, 1'b0, 5'd0, 1, 4'hF, 4'd4);
        wd[0] = 32'hAABBCCDD;
        wr(30'h80, 1'b0, 5'd0, 1, 4'b0101, 4'd4);
        ew[0] = 32'h11BB33DD;
        rd(30'h80, 1'b1, 1'b0, 5'd0, 1, 4'd6);

        wd[0] = 32'h12345678;
        wr(30'h10, 1'b0, 5'd0, 1, 4'hF, 4'd7);
        @(posedge clk); #1;
        bus.abort_request = 1'b1;
        @(posedge clk); #1;
        bus.abort_request = 1'b0;
        sc(30'h10, 1'b0, 1'b0, 4'd8);
        ew[0] = 32'h12345678;
        rd(30'h10, 1'b1, 1'b0, 5'd0, 1, 4'd10);
        sc(30'h10, 1'b1, 1'b1, 4'd11);
        rd(30'h10, 1'b1, 1'b0, 5'd0, 1, 4'd12);
        wd[0] = 32'h5;
        wr(30'h10, 1'b1, 5'b00011, 1, 4'hF, 4'd13);
        ew[0] = 32'h5;
        rd(30'h10, 1'b1, 1'b0, 5'd0, 1, 4'd14);

        rd(30'h10, 1'b0, 1'b1, 5'b00010, 1, 4'd15);

`ifdef L2_RESP_AMO_EN
        wd[0] = 32'h7;
        wr(30'h20, 1'b0, 5'd0, 1, 4'hF, 4'd1);
        amo(30'h20, 5'b00000, 32'h5, 32'h7, 4'd2);
        ew[0] = 32'hC;
        rd(30'h20, 1'b1, 1'b0, 5'd0, 1, 4'd3);
        amo(30'h20, 5'b10000, 32'hFFFF_FFFF, 32'hC, 4'd4);
        ew[0] = 32'hFFFF_FFFF;
        rd(30'h20, 1'b1, 1'b0, 5'd0, 1, 4'd5);
        amo(30'h20, 5'b11100, 32'h5, 32'hFFFF_FFFF, 4'd6);
        rd(30'h20, 1'b1, 1'b0, 5'd0, 1, 4'd7);
`else
        wd[0] = 32'h99;
        wr(30'h20, 1'b1, 5'b00100, 1, 4'hF, 4'd1);
        ew[0] = 32'h99;
        rd(30'h20, 1'b1, 1'b0, 5'd0, 1, 4'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
